// File: rtl/vga_timing_gen_if.sv
// Raster-scan bundle between the timing generator (master) and its consumers (slave).
interface vga_timing_gen_if;
  logic        pix_ce;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    input  pix_ce,
    output DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );

  modport slave (
    output pix_ce,
    input  DrawX, DrawY, blank, hs, vs, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running pixel/line counters with registered blank/sync/frame strobe.
// Optional frame counter built only when VGA_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter bit          HS_POL    = 1'b0,
  parameter bit          VS_POL    = 1'b0
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FP + V_SYNC);

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       fs_q, fs_d;

  // Flags are decoded from the next counter values so they line up with DrawX/DrawY.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (vif.pix_ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
    blank_d = (x_d < H_VIS) && (y_d < V_VIS);
    hs_d    = ((x_d >= HS_START) && (x_d < HS_END)) ? HS_POL : ~HS_POL;
    vs_d    = ((y_d >= VS_START) && (y_d < VS_END)) ? VS_POL : ~VS_POL;
    fs_d    = vif.pix_ce && (x_d == '0) && (y_d == '0);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q     <= H_LAST;
      y_q     <= V_LAST;
      blank_q <= 1'b0;
      hs_q    <= ~HS_POL;
      vs_q    <= ~VS_POL;
      fs_q    <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      blank_q <= blank_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      fs_q    <= fs_d;
    end
  end

`ifdef VGA_FRAME_CNT_EN
  logic [15:0] fc_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      fc_q <= '0;
    end else if (fs_d) begin
      fc_q <= fc_q + 16'd1;
    end
  end

  assign vif.frame_count = fc_q;
`else
  assign vif.frame_count = '0;
`endif

  assign vif.DrawX       = x_q;
  assign vif.DrawY       = y_q;
  assign vif.blank       = blank_q;
  assign vif.hs          = hs_q;
  assign vif.vs          = vs_q;
  assign vif.frame_start = fs_q;

endmodule
